// File: rtl/dmni_mem_arbiter_pkg.sv
// Shared types for the DMNI local-memory arbiter: requester indices,
// per-requester access record, arbiter FSM states and a one-hot helper.
package dmni_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_REQ_SEND    = 2'd0,
    MEM_REQ_RECEIVE = 2'd1,
    MEM_REQ_MON     = 2'd2,
    MEM_NREQ        = 2'd3
  } dmni_mem_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } dmni_mem_acc_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

  localparam int unsigned NUM_REQ = 3;

  // One-hot grant vector for a requester index; MEM_NREQ maps to no grant.
  function automatic logic [2:0] req_onehot(input dmni_mem_req_t r);
    logic [2:0] oh;
    oh = 3'b000;
    case (r)
      MEM_REQ_SEND:    oh = 3'b001;
      MEM_REQ_RECEIVE: oh = 3'b010;
      MEM_REQ_MON:     oh = 3'b100;
      default:         oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dmni_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index
// after `last` in the cyclic order SEND -> RECEIVE -> MON -> SEND.
module dmni_rr_pick
  import dmni_mem_arbiter_pkg::*;
(
  input  logic [2:0]    req,
  input  dmni_mem_req_t last,
  output dmni_mem_req_t winner,
  output logic          valid
);

  // Priority order rotates so the index just after `last` is checked first.
  always_comb begin
    winner = MEM_REQ_SEND;
    valid  = |req;
    case (last)
      MEM_REQ_SEND: begin
        if (req[1])      winner = MEM_REQ_RECEIVE;
        else if (req[2]) winner = MEM_REQ_MON;
        else             winner = MEM_REQ_SEND;
      end
      MEM_REQ_RECEIVE: begin
        if (req[2])      winner = MEM_REQ_MON;
        else if (req[0]) winner = MEM_REQ_SEND;
        else             winner = MEM_REQ_RECEIVE;
      end
      default: begin
        if (req[0])      winner = MEM_REQ_SEND;
        else if (req[1]) winner = MEM_REQ_RECEIVE;
        else             winner = MEM_REQ_MON;
      end
    endcase
  end

endmodule

// File: rtl/dmni_mem_arbiter.sv
// Single-port local-memory arbiter for the DMNI. Three requesters share one
// 32-bit port with round-robin arbitration and burst holding; a new owner is
// chosen in the same cycle the previous one releases, so handover has no
// bubble. Grants and memory strobes are combinational; state is registered.
module dmni_mem_arbiter
  import dmni_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       req_i,
  input  logic [2:0][31:0] req_addr_i,
  input  logic [2:0][3:0]  req_we_i,
  input  logic [2:0][31:0] req_data_i,
  output logic [2:0]       gnt_o,
  output logic [2:0]       rdata_valid_o,
  output logic [31:0]      rdata_o,
  input  logic             mem_ready_i,
  output logic             mem_en_o,
  output logic [3:0]       mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  input  logic [31:0]      mem_data_i,
  output logic             busy_o
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_t    state_reg;
  dmni_mem_req_t owner_reg;
  dmni_mem_req_t last_reg;
  logic [7:0]    burst_cnt_reg;
  logic [2:0]    rdata_valid_reg;

  dmni_mem_acc_t acc [NUM_REQ];
  logic [31:0]   addr_m [NUM_REQ];
  logic [3:0]    we_m   [NUM_REQ];
  logic [31:0]   data_m [NUM_REQ];
  logic [2:0]    rdata_valid_next;

  logic [2:0]    owner_oh;
  logic          owner_req;
  logic          hold;
  dmni_mem_req_t pick_winner;
  logic          pick_valid;
  logic [2:0]    gnt_sel;
  logic [2:0]    gnt;

  dmni_rr_pick u_pick (
    .req    (req_i),
    .last   (last_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // Current owner keeps the port while it still asks and has burst budget left.
  assign owner_oh  = req_onehot(owner_reg);
  assign owner_req = |(req_i & owner_oh);
  assign hold      = (state_reg == ST_OWNED) && owner_req && (burst_cnt_reg < MAX_BURST_C);

  assign gnt_sel = hold ? owner_oh : (pick_valid ? req_onehot(pick_winner) : 3'b000);
  // A stalled memory or an active reset suppresses every grant.
  assign gnt     = (mem_ready_i && !rst_i) ? gnt_sel : 3'b000;

  // Per-requester access records and AND-OR mux legs keyed on the grant.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign acc[gi]    = '{addr: req_addr_i[gi], we: req_we_i[gi], data: req_data_i[gi]};
      assign addr_m[gi] = gnt[gi] ? acc[gi].addr : 32'h0;
      assign we_m[gi]   = gnt[gi] ? acc[gi].we   : 4'h0;
      assign data_m[gi] = gnt[gi] ? acc[gi].data : 32'h0;
      assign rdata_valid_next[gi] = gnt[gi] && (acc[gi].we == 4'h0);
    end
  endgenerate

  assign mem_en_o   = |gnt;
  assign mem_addr_o = addr_m[0] | addr_m[1] | addr_m[2];
  assign mem_we_o   = we_m[0]   | we_m[1]   | we_m[2];
  assign mem_data_o = data_m[0] | data_m[1] | data_m[2];

  assign gnt_o         = gnt;
  assign rdata_o       = mem_data_i;
  // Masked during reset so a read granted just before reset never reports data.
  assign rdata_valid_o = rst_i ? 3'b000 : rdata_valid_reg;
  assign busy_o        = (state_reg == ST_OWNED) && !rst_i;

  // Arbiter FSM: hold, hand over or go idle on each accepted cycle; freeze on stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      owner_reg       <= MEM_REQ_SEND;
      last_reg        <= MEM_REQ_MON;
      burst_cnt_reg   <= 8'd0;
      rdata_valid_reg <= 3'b000;
    end else begin
      rdata_valid_reg <= rdata_valid_next;
      if (mem_ready_i) begin
        if (hold) begin
          burst_cnt_reg <= burst_cnt_reg + 8'd1;
        end else if (pick_valid) begin
          state_reg     <= ST_OWNED;
          owner_reg     <= pick_winner;
          last_reg      <= pick_winner;
          burst_cnt_reg <= 8'd1;
        end else begin
          state_reg     <= ST_IDLE;
          burst_cnt_reg <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Table-driven bench for dmni_mem_arbiter with MAX_BURST = 4.
module tb_dmni_mem_arbiter;

  logic             clk;
  logic             rst;
  logic [2:0]       req;
  logic [2:0][31:0] req_addr;
  logic [2:0][3:0]  req_we;
  logic [2:0][31:0] req_data;
  logic [2:0]       gnt;
  logic [2:0]       rdata_valid;
  logic [31:0]      rdata;
  logic             mem_ready;
  logic             mem_en;
  logic [3:0]       mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_data_out;
  logic [31:0]      mem_data_in;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  dmni_mem_arbiter #(.MAX_BURST(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .req_addr_i    (req_addr),
    .req_we_i      (req_we),
    .req_data_i    (req_data),
    .gnt_o         (gnt),
    .rdata_valid_o (rdata_valid),
    .rdata_o       (rdata),
    .mem_ready_i   (mem_ready),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_data_out),
    .mem_data_i    (mem_data_in),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       ready;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] rv;
    logic       busy;
  } vec_t;

  localparam int NV = 47;
  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Check every output against the expected grant/valid/busy triple.
  task automatic check_all(input int idx, input logic [2:0] eg, input logic [2:0] erv, input logic eb);
    logic [31:0] ea;
    logic [3:0]  ew;
    logic [31:0] ed;
    ea = 32'h0; ew = 4'h0; ed = 32'h0;
    case (eg)
      3'b001: begin ea = 32'h0000_0100; ew = 4'h0; ed = 32'hA0A0_A0A0; end
      3'b010: begin ea = 32'h0000_0200; ew = 4'hF; ed = 32'h1111_1111; end
      3'b100: begin ea = 32'h0000_0300; ew = 4'h3; ed = 32'h2222_2222; end
      default: ;
    endcase
    check("gnt",         idx, 32'(gnt),          32'(eg));
    check("rdata_valid", idx, 32'(rdata_valid),  32'(erv));
    check("busy",        idx, 32'(busy),         32'(eb));
    check("mem_en",      idx, 32'(mem_en),       32'(eg != 3'b000));
    check("mem_addr",    idx, mem_addr,          ea);
    check("mem_we",      idx, 32'(mem_we),       32'(ew));
    check("mem_data",    idx, mem_data_out,      ed);
    check("rdata",       idx, rdata,             mem_data_in);
    $display("vec %0d rst=%0b rdy=%0b req=%03b gnt=%03b rv=%03b busy=%0b addr=0x%08h",
             idx, rst, mem_ready, req, gnt, rdata_valid, busy, mem_addr);
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic [2:0] rq,
                              input logic [2:0] g, input logic [2:0] v, input logic b);
    vec_t t;
    t.rst = r; t.ready = rd; t.req = rq; t.gnt = g; t.rv = v; t.busy = b;
    return t;
  endfunction

  initial begin
    // Reset state
    vecs[0]  = mk(1, 1, 3'b000, 3'b000, 3'b000, 0);
    // Single read by SEND
    vecs[1]  = mk(0, 1, 3'b001, 3'b001, 3'b000, 0);
    vecs[2]  = mk(0, 1, 3'b000, 3'b000, 3'b001, 1);
    vecs[3]  = mk(0, 1, 3'b000, 3'b000, 3'b000, 0);
    // Re-reset so SEND leads the rotation
    vecs[4]  = mk(1, 1, 3'b000, 3'b000, 3'b000, 0);
    // Rotation: 4xSEND, 4xRECEIVE, 4xMON, 4xSEND
    vecs[5]  = mk(0, 1, 3'b111, 3'b001, 3'b000, 0);
    vecs[6]  = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[7]  = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[8]  = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[9]  = mk(0, 1, 3'b111, 3'b010, 3'b001, 1);
    vecs[10] = mk(0, 1, 3'b111, 3'b010, 3'b000, 1);
    vecs[11] = mk(0, 1, 3'b111, 3'b010, 3'b000, 1);
    vecs[12] = mk(0, 1, 3'b111, 3'b010, 3'b000, 1);
    vecs[13] = mk(0, 1, 3'b111, 3'b100, 3'b000, 1);
    vecs[14] = mk(0, 1, 3'b111, 3'b100, 3'b000, 1);
    vecs[15] = mk(0, 1, 3'b111, 3'b100, 3'b000, 1);
    vecs[16] = mk(0, 1, 3'b111, 3'b100, 3'b000, 1);
    vecs[17] = mk(0, 1, 3'b111, 3'b001, 3'b000, 1);
    vecs[18] = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[19] = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[20] = mk(0, 1, 3'b111, 3'b001, 3'b001, 1);
    vecs[21] = mk(0, 1, 3'b000, 3'b000, 3'b001, 1);
    // Stall: RECEIVE at count 2, ready low 3 cycles, resumes at 3 then hands to SEND
    vecs[22] = mk(0, 1, 3'b010, 3'b010, 3'b000, 0);
    vecs[23] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[24] = mk(0, 0, 3'b010, 3'b000, 3'b000, 1);
    vecs[25] = mk(0, 0, 3'b010, 3'b000, 3'b000, 1);
    vecs[26] = mk(0, 0, 3'b010, 3'b000, 3'b000, 1);
    vecs[27] = mk(0, 1, 3'b011, 3'b010, 3'b000, 1);
    vecs[28] = mk(0, 1, 3'b011, 3'b010, 3'b000, 1);
    vecs[29] = mk(0, 1, 3'b011, 3'b001, 3'b000, 1);
    vecs[30] = mk(0, 1, 3'b000, 3'b000, 3'b001, 1);
    // Early release: MON drops after 2 accesses, waiting SEND wins next cycle
    vecs[31] = mk(0, 1, 3'b100, 3'b100, 3'b000, 0);
    vecs[32] = mk(0, 1, 3'b101, 3'b100, 3'b000, 1);
    vecs[33] = mk(0, 1, 3'b001, 3'b001, 3'b000, 1);
    vecs[34] = mk(0, 1, 3'b000, 3'b000, 3'b001, 1);
    // Sole re-win: RECEIVE alone, granted every cycle across the 4->1 wrap
    vecs[35] = mk(0, 1, 3'b010, 3'b010, 3'b000, 0);
    vecs[36] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[37] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[38] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[39] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[40] = mk(0, 1, 3'b010, 3'b010, 3'b000, 1);
    vecs[41] = mk(0, 1, 3'b000, 3'b000, 3'b000, 1);
    // Reset mid SEND read burst
    vecs[42] = mk(0, 1, 3'b001, 3'b001, 3'b000, 0);
    vecs[43] = mk(0, 1, 3'b001, 3'b001, 3'b001, 1);
    vecs[44] = mk(1, 1, 3'b001, 3'b000, 3'b000, 0);
    vecs[45] = mk(0, 1, 3'b001, 3'b001, 3'b000, 0);
    vecs[46] = mk(0, 1, 3'b000, 3'b000, 3'b001, 1);

    req_addr[0] = 32'h0000_0100; req_we[0] = 4'h0; req_data[0] = 32'hA0A0_A0A0;
    req_addr[1] = 32'h0000_0200; req_we[1] = 4'hF; req_data[1] = 32'h1111_1111;
    req_addr[2] = 32'h0000_0300; req_we[2] = 4'h3; req_data[2] = 32'h2222_2222;
    mem_data_in = 32'hDEAD_BEEF;
    mem_ready   = 1'b1;
    req         = 3'b000;
    rst         = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      mem_ready = vecs[i].ready;
      req       = vecs[i].req;
      #1;
      check_all(i, vecs[i].gnt, vecs[i].rv, vecs[i].busy);
    end

    // Hand sequence: read data follows mem_data_i one cycle after the grant.
    @(negedge clk);
    req = 3'b001;
    mem_data_in = 32'h1234_5678;
    #1;
    check("hs_gnt", 100, 32'(gnt), 32'h1);
    check("hs_rv0", 100, 32'(rdata_valid), 32'h0);
    @(negedge clk);
    req = 3'b000;
    #1;
    check("hs_rv1", 101, 32'(rdata_valid), 32'h1);
    check("hs_rdata", 101, rdata, 32'h1234_5678);
    check("hs_gnt_off", 101, 32'(gnt), 32'h0);
    $display("hand seq read: rv=%03b rdata=0x%08h", rdata_valid, rdata);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
